// File: rtl/multi_vlp.sv
// multi_vlp: shift-add multiplier with early termination, signed/unsigned operands and a cycle count.
module multi_vlp #(
   parameter int WIDTH = 32,
   localparam int CW = $clog2(WIDTH + 2)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [WIDTH-1:0]   mlier,
   input  logic [WIDTH-1:0]   mcand,
   input  logic               sgn,
   input  logic               start,
   output logic [2*WIDTH-1:0] prodt,
   output logic               valid,
   output logic               busy,
   output logic [CW-1:0]      cycles
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] mlr, mag_lr, mag_cd;
   logic [2*WIDTH-1:0] mcd, acc;
   logic [CW-1:0] cnt;
   logic neg;
   // magnitude is taken in WIDTH bits, so the most negative value maps to 2^(WIDTH-1)
   assign mag_lr = (sgn && mlier[WIDTH-1]) ? -mlier : mlier;
   assign mag_cd = (sgn && mcand[WIDTH-1]) ? -mcand : mcand;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state  <= IDLE;
         mlr    <= '0;
         mcd    <= '0;
         acc    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         prodt  <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
         cycles <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  neg   <= sgn & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
                  mlr   <= mag_lr;
                  mcd   <= {{WIDTH{1'b0}}, mag_cd};
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            CALC:
               if (mlr == '0 || mcd == '0) begin
                  prodt  <= neg ? -acc : acc;
                  cycles <= cnt + CW'(1);
                  valid  <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else begin
                  if (mlr[0]) acc <= acc + mcd;
                  mlr <= mlr >> 1;
                  mcd <= mcd << 1;
                  cnt <= cnt + CW'(1);
               end
            DONE:
               if (!start) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_multi_vlp.sv
// tb_multi_vlp: vector table, handshake/reset sequences and random pairs against a product model.
module tb_multi_vlp;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mlier = '0, mcand = '0;
   logic        sgn = 1'b0, start = 1'b0;
   logic [63:0] prodt;
   logic        valid, busy;
   logic [5:0]  cycles;
   int total = 0, bad = 0;

   multi_vlp #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .mlier(mlier), .mcand(mcand), .sgn(sgn),
      .start(start), .prodt(prodt), .valid(valid), .busy(busy), .cycles(cycles)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a, b;
      logic        s;
      logic [63:0] p;
      int          c;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, b, input logic s);
      logic signed [63:0] sa, sb;
      sa = s ? {{32{a[31]}}, a} : {32'b0, a};
      sb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return sa * sb;
   endfunction

   function automatic int ref_cyc(input logic [31:0] a, b, input logic s);
      longint ma, mb;
      int k;
      ma = (s && a[31]) ? 64'h1_0000_0000 - a : a;
      mb = (s && b[31]) ? 64'h1_0000_0000 - b : b;
      k = 0;
      if (mb != 0)
         for (int i = 0; i < 32; i++) if (ma[i]) k = i + 1;
      return k + 1;
   endfunction

   task automatic run_op(input string nm, input logic [31:0] a, b, input logic s,
                         input logic [63:0] ep, input int ec, input int hold);
      int n;
      logic stay;
      mlier = a; mcand = b; sgn = s; start = 1'b1;
      @(posedge clock); #1;
      chk({nm, " busy_e0"}, busy, 1);
      mlier = $urandom; mcand = $urandom; sgn = 1'($urandom);
      n = 0;
      while (!valid && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      chk({nm, " latency"}, n, ec);
      chk({nm, " prodt"}, prodt, ep);
      chk({nm, " cycles"}, cycles, ec);
      chk({nm, " busy_done"}, busy, 0);
      if (hold > 0) begin
         stay = 1'b1;
         repeat (hold) begin
            @(posedge clock); #1;
            if (!valid || prodt !== ep || busy) stay = 1'b0;
         end
         chk({nm, " hold"}, stay, 1);
      end
      start = 1'b0;
      @(posedge clock); #1;
      chk({nm, " valid_clr"}, valid, 0);
      chk({nm, " prodt_keep"}, prodt, ep);
      chk({nm, " cycles_keep"}, cycles, ec);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, b;
      logic s;
      vecs[0] = '{32'd3, 32'd5, 1'b0, 64'd15, 3};
      vecs[1] = '{-32'sd7, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 4};
      vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33};
      vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33};
      vecs[4] = '{32'd0, 32'h1234_5678, 1'b0, 64'd0, 1};
      vecs[5] = '{32'hFFFF_FFFF, 32'd0, 1'b0, 64'd0, 1};
      vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, 2};
      vecs[7] = '{32'd1, 32'd1, 1'b0, 64'd1, 2};
      vecs[8] = '{32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 33};
      vecs[9] = '{32'd5, 32'h8000_0000, 1'b1, 64'hFFFF_FFFD_8000_0000, 4};
      #12;
      chk("rst prodt", prodt, 0);
      chk("rst valid", valid, 0);
      chk("rst busy", busy, 0);
      chk("rst cycles", cycles, 0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, vecs[i].c, 0);
      run_op("hold40", 32'd3, 32'd5, 1'b0, 64'd15, 3, 40);
      run_op("restart", -32'sd7, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 4, 0);
      mlier = 32'hFFFF_FFFF; mcand = 32'd3; sgn = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("abort prodt", prodt, 0);
      chk("abort valid", valid, 0);
      chk("abort busy", busy, 0);
      chk("abort cycles", cycles, 0);
      @(negedge clock);
      reset = 1'b1;
      run_op("post_rst", 32'd3, 32'd5, 1'b0, 64'd15, 3, 0);
      for (int i = 0; i < 200; i++) begin
         a = $urandom >> $urandom_range(0, 31);
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) a = -a;
         if ($urandom_range(0, 3) == 0) b = -b;
         s = 1'($urandom);
         run_op($sformatf("rnd%0d", i), a, b, s, ref_prod(a, b, s), ref_cyc(a, b, s), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_vlp.md
MULTI_VLP -- requirements
Module: multi_vlp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal range 4..64).
REQ-002 SHALL have derived localparam CW = clog2(WIDTH+2), meaning the width of the cycle-count output.
REQ-003 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clock.
REQ-005 SHALL have port mlier  input  WIDTH  multiplier operand.
REQ-006 SHALL have port mcand  input  WIDTH  multiplicand operand.
REQ-007 SHALL have port sgn  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-008 SHALL have port start  input  1  level request; sampled only in IDLE.
REQ-009 SHALL have port prodt  output  2*WIDTH  product; two's-complement when sgn=1.
REQ-010 SHALL have port valid  output  1  prodt holds the result of the current request.
REQ-011 SHALL have port busy  output  1  high in CALC state.
REQ-012 SHALL have port cycles  output  CW  number of CALC edges the last operation consumed.

Function
REQ-013 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-014 IDLE: at a rising edge with start=1, SHALL capture sgn, |mlier|, |mcand| and neg = sgn & (mlier[MSB] ^ mcand[MSB]); SHALL clear accumulator and counter; SHALL go to CALC. This edge is E0.
REQ-015 Magnitude rule: when sgn=1, |x| SHALL be the WIDTH-bit unsigned magnitude, so -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow; when sgn=0, |x| = x.
REQ-016 The multiplicand register SHALL be 2*WIDTH wide and zero-extended; the multiplier register SHALL be WIDTH wide.
REQ-017 CALC, each edge, when the multiplier register is nonzero and the multiplicand register is nonzero: add the multiplicand register to the accumulator if multiplier bit 0 = 1; shift the multiplier right 1; shift the multiplicand left 1; increment the counter.
REQ-018 CALC, at an edge with multiplier = 0 or multiplicand = 0 (early termination): prodt <= neg ? -acc : acc (2*WIDTH modulo); cycles <= counter + 1; valid <= 1; go to DONE.
REQ-019 Latency definition: k = 0 if |mcand| = 0, otherwise k = index of the MSB of |mlier| + 1 (k = 0 if |mlier| = 0).
REQ-020 Latency SHALL be k+1 edges after E0: valid is high after edge E(k+1), cycles = k+1, maximum WIDTH+1.
REQ-021 busy SHALL be 1 exactly while in CALC.
REQ-022 DONE: valid and prodt SHALL hold while start=1.
REQ-023 DONE: at the first edge with start=0, SHALL clear valid and go to IDLE; prodt and cycles SHALL retain their values.
REQ-024 Operand and sgn changes after E0 SHALL be ignored until the next acceptance in IDLE.
REQ-025 start SHALL have no effect in CALC.
REQ-026 A new request SHALL need start low for at least one edge after DONE; start held high never restarts the operation.
REQ-027 The accumulator SHALL never overflow 2*WIDTH bits for any legal operand pair.

Reset
REQ-028 While reset=0: state = IDLE, prodt = 0, valid = 0, busy = 0, cycles = 0; all internal registers cleared.
REQ-029 Reset assertion mid-CALC or in DONE SHALL abort the operation at once with no partial result visible.
REQ-030 The first edge with reset=1 and start=1 SHALL be accepted as E0.

Verification (WIDTH=32)
REQ-031 Unsigned basic: sgn=0, 3 x 5 -> prodt = 15, valid after E3, cycles = 3, busy high after E0..E2.
REQ-032 Signed mixed: sgn=1, -7 x 6 -> prodt = 64'hFFFF_FFFF_FFFF_FFD6, valid after E4, cycles = 4.
REQ-033 Signed extremes: sgn=1, 32'h8000_0000 x 32'h8000_0000 -> prodt = 64'h4000_0000_0000_0000, cycles = 33; sgn=0, 32'hFFFF_FFFF x 32'hFFFF_FFFF -> prodt = 64'hFFFF_FFFE_0000_0001, cycles = 33.
REQ-034 Early termination: 0 x 32'h1234_5678 and 32'hFFFF_FFFF x 0 -> prodt = 0, valid after E1, cycles = 1.
REQ-035 Handshake: change operands during CALC -> result from E0 operands; hold start 40 edges -> valid stays high; drop start -> valid low after the next edge; re-raise start -> new E0.
REQ-036 Reset mid-operation: pull reset low at E5 of 32'hFFFF_FFFF x 3 -> prodt = 0, valid = 0, busy = 0 immediately; after release, 3 x 5 completes correctly with cycles = 3.
REQ-037 Random: 200 random signed and unsigned pairs, each checked against the reference product and against cycles = k+1.
